// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply/divide control stage.
package hilo_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned TIMEOUT_DEF = 40;
  localparam int unsigned OPC_W       = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 3'd0,
    OP_MULT = 3'd1,
    OP_DIV  = 3'd2,
    OP_MTHI = 3'd3,
    OP_MTLO = 3'd4,
    OP_MFHI = 3'd5,
    OP_MFLO = 3'd6
  } op_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_M_ACK,
    ST_M_DONE,
    ST_D_ACK,
    ST_D_DONE
  } hilo_state_e;

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_ACK,
    ENG_DONE
  } eng_state_e;

  // Fold the two engine sub-FSMs into the stage-level state view.
  function automatic hilo_state_e merge_state(input eng_state_e m, input eng_state_e d);
    hilo_state_e s;
    s = ST_IDLE;
    if (m == ENG_ACK)       s = ST_M_ACK;
    else if (m == ENG_DONE) s = ST_M_DONE;
    else if (d == ENG_ACK)  s = ST_D_ACK;
    else if (d == ENG_DONE) s = ST_D_DONE;
    return s;
  endfunction

endpackage

// File: rtl/hilo_ctrl_eng_handshake.sv
// Start/fim handshake sequencer for one sequential engine, with wait-state timeout.
module eng_handshake
  import hilo_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic       fim,
  output logic       start_c,
  output logic       done_c,
  output logic       timeout_c,
  output eng_state_e state
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  eng_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_end;

  assign cnt_end = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign state   = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ENG_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Start drops as soon as fim is seen high in DONE, so the engine cannot restart.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_c   = 1'b0;
    done_c    = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      ENG_IDLE: begin
        if (go) begin
          state_d = ENG_ACK;
          cnt_d   = '0;
        end
      end
      ENG_ACK: begin
        start_c = 1'b1;
        if (!fim) begin
          state_d = ENG_DONE;
          cnt_d   = '0;
        end else if (cnt_end) begin
          timeout_c = 1'b1;
          state_d   = ENG_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ENG_DONE: begin
        start_c = !fim;
        if (fim) begin
          done_c  = 1'b1;
          state_d = ENG_IDLE;
        end else if (cnt_end) begin
          timeout_c = 1'b1;
          state_d   = ENG_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ENG_IDLE;
    endcase
  end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO control stage: decodes mul/div/move requests, drives engine handshakes, owns HI/LO.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [OPC_W-1:0] op_code,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             op_ready,
  output logic             stall,
  output logic [WIDTH-1:0] mf_data,
  output logic             mult_start,
  output logic [WIDTH-1:0] mult_op1,
  output logic [WIDTH-1:0] mult_op2,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic             mult_fim,
  output logic             div_start,
  output logic [WIDTH-1:0] div_op1,
  output logic [WIDTH-1:0] div_op2,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  input  logic             div_fim,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic             busy,
  output logic             div_by_zero,
  output logic             timeout_err
);

  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH-1:0] mult_op1_q, mult_op1_d, mult_op2_q, mult_op2_d;
  logic [WIDTH-1:0] div_op1_q, div_op1_d, div_op2_q, div_op2_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             timeout_err_q, timeout_err_d;

  logic        accept_c;
  op_code_e    opc_c;
  hilo_state_e state_c;
  eng_state_e  mult_state, div_state;
  logic        mult_go_c, div_go_c;
  logic        mult_done_c, div_done_c;
  logic        mult_to_c, div_to_c;

  eng_handshake #(.TIMEOUT(TIMEOUT)) u_mult_hs (
    .clock     (clock),
    .reset     (reset),
    .go        (mult_go_c),
    .fim       (mult_fim),
    .start_c   (mult_start),
    .done_c    (mult_done_c),
    .timeout_c (mult_to_c),
    .state     (mult_state)
  );

  eng_handshake #(.TIMEOUT(TIMEOUT)) u_div_hs (
    .clock     (clock),
    .reset     (reset),
    .go        (div_go_c),
    .fim       (div_fim),
    .start_c   (div_start),
    .done_c    (div_done_c),
    .timeout_c (div_to_c),
    .state     (div_state)
  );

  assign state_c  = merge_state(mult_state, div_state);
  assign op_ready = (state_c == ST_IDLE);
  assign busy     = !op_ready;
  assign stall    = op_valid && !op_ready;
  assign accept_c = op_valid && op_ready;
  assign opc_c    = op_code_e'(op_code);

  assign mult_op1    = mult_op1_q;
  assign mult_op2    = mult_op2_q;
  assign div_op1     = div_op1_q;
  assign div_op2     = div_op2_q;
  assign div_by_zero = div_by_zero_q;
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q          <= '0;
      lo_q          <= '0;
      mult_op1_q    <= '0;
      mult_op2_q    <= '0;
      div_op1_q     <= '0;
      div_op2_q     <= '0;
      div_by_zero_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      mult_op1_q    <= mult_op1_d;
      mult_op2_q    <= mult_op2_d;
      div_op1_q     <= div_op1_d;
      div_op2_q     <= div_op2_d;
      div_by_zero_q <= div_by_zero_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Request decode; engine results land in HI/LO only on a clean done, never on abort.
  always_comb begin
    hi_d          = hi_q;
    lo_d          = lo_q;
    mult_op1_d    = mult_op1_q;
    mult_op2_d    = mult_op2_q;
    div_op1_d     = div_op1_q;
    div_op2_d     = div_op2_q;
    div_by_zero_d = div_by_zero_q;
    timeout_err_d = timeout_err_q;
    mult_go_c     = 1'b0;
    div_go_c      = 1'b0;
    mf_data       = '0;

    if (accept_c) begin
      case (opc_c)
        OP_MULT: begin
          mult_go_c  = 1'b1;
          mult_op1_d = rs_val;
          mult_op2_d = rt_val;
        end
        OP_DIV: begin
          if (rt_val == '0) begin
            div_by_zero_d = 1'b1;
          end else begin
            div_go_c  = 1'b1;
            div_op1_d = rs_val;
            div_op2_d = rt_val;
          end
        end
        OP_MTHI: hi_d    = rs_val;
        OP_MTLO: lo_d    = rs_val;
        OP_MFHI: mf_data = hi_q;
        OP_MFLO: mf_data = lo_q;
        default: ;
      endcase
    end

    if (mult_done_c) begin
      hi_d = mult_hi;
      lo_d = mult_lo;
    end
    if (div_done_c) begin
      hi_d = div_hi;
      lo_d = div_lo;
    end
    if (mult_to_c || div_to_c) timeout_err_d = 1'b1;
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl with behavioural mult/div engines and a HI/LO scoreboard.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 40;
  localparam int          N       = 33;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             op_valid = 1'b0;
  logic [2:0]       op_code = 3'd0;
  logic [WIDTH-1:0] rs_val = '0;
  logic [WIDTH-1:0] rt_val = '0;
  logic             op_ready, stall, busy, div_by_zero, timeout_err;
  logic [WIDTH-1:0] mf_data, hi_q, lo_q;
  logic             mult_start, div_start;
  logic [WIDTH-1:0] mult_op1, mult_op2, div_op1, div_op2;
  logic [WIDTH-1:0] mult_hi, mult_lo, div_hi, div_lo;
  logic             mult_fim, div_fim;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic        prev_busy = 1'b0;

  bit m_hang = 1'b0;
  int m_cnt, d_cnt;
  int m_loads = 0;
  int d_loads = 0;

  always #5 clock = ~clock;

  hilo_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .op_ready(op_ready), .stall(stall),
    .mf_data(mf_data), .mult_start(mult_start), .mult_op1(mult_op1),
    .mult_op2(mult_op2), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .mult_fim(mult_fim), .div_start(div_start), .div_op1(div_op1),
    .div_op2(div_op2), .div_hi(div_hi), .div_lo(div_lo), .div_fim(div_fim),
    .hi_q(hi_q), .lo_q(lo_q), .busy(busy), .div_by_zero(div_by_zero),
    .timeout_err(timeout_err)
  );

  // Signed multiplier model: loads on start while idle, result after N cycles.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mult_fim <= 1'b1;
      m_cnt    <= 0;
      mult_hi  <= '0;
      mult_lo  <= '0;
    end else if (mult_fim && mult_start && !m_hang) begin
      longint p;
      p = longint'($signed(mult_op1)) * longint'($signed(mult_op2));
      mult_fim <= 1'b0;
      m_cnt    <= N;
      m_loads  <= m_loads + 1;
      {mult_hi, mult_lo} <= p;
    end else if (!mult_fim) begin
      if (m_cnt == 1) mult_fim <= 1'b1;
      m_cnt <= m_cnt - 1;
    end
  end

  // Signed divider model: hi = remainder, lo = quotient.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      div_fim <= 1'b1;
      d_cnt   <= 0;
      div_hi  <= '0;
      div_lo  <= '0;
    end else if (div_fim && div_start) begin
      int a, b;
      a = $signed(div_op1);
      b = $signed(div_op2);
      div_fim <= 1'b0;
      d_cnt   <= N;
      d_loads <= d_loads + 1;
      div_hi  <= (b != 0) ? 32'(a % b) : '0;
      div_lo  <= (b != 0) ? 32'(a / b) : '0;
    end else if (!div_fim) begin
      if (d_cnt == 1) div_fim <= 1'b1;
      d_cnt <= d_cnt - 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each engine op ends when busy falls; HI/LO must match the queued expectation.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        logic [63:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        check_val("sb_hilo", {hi_q, lo_q}, e);
      end
      prev_busy = busy;
    end
  end

  // Called aligned #1 after a posedge; returns aligned #1 after the accepting posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] mf, output int stalls);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    mf = '0;
    op_valid = 1'b1;
    op_code  = op;
    rs_val   = a;
    rt_val   = b;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (op_ready) begin
        ok = 1'b1;
        mf = mf_data;
        break;
      end
      if (stall) stalls++;
    end
    if (!ok) check_val("accept_bound", 64'(ok), 64'd1);
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    op_code  = 3'd0;
  endtask

  // Waits for busy to fall, checking start level and op_ready each busy cycle.
  task automatic wait_idle(input bit is_div, output int cyc, output int errs);
    bit seen_low, ok, fim_v, st_v, other_st;
    seen_low = 1'b0;
    ok = 1'b0;
    cyc = 0;
    errs = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      cyc++;
      fim_v    = is_div ? div_fim : mult_fim;
      st_v     = is_div ? div_start : mult_start;
      other_st = is_div ? mult_start : div_start;
      if (!fim_v) seen_low = 1'b1;
      if (st_v !== !(fim_v && seen_low)) errs++;
      if (other_st || op_ready) errs++;
    end
    if (!ok) check_val("idle_bound", 64'(ok), 64'd1);
  endtask

  initial begin
    logic [31:0] mf;
    int stalls, cyc, errs, loads0, cnt;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_val("rst_hilo", {hi_q, lo_q}, 64'd0);
    check_val("rst_flags", {busy, mult_start, div_start, div_by_zero, timeout_err, stall},
              6'b0);
    check_val("rst_ready", 64'(op_ready), 64'd1);
    check_val("rst_ops", {mult_op1, div_op2}, 64'd0);
    @(posedge clock);
    #1;

    // MULT 7 * -3
    loads0 = m_loads;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
    issue(3'(OP_MULT), 32'd7, 32'hFFFF_FFFD, mf, stalls);
    check_val("mult_ops", {mult_op1, mult_op2}, {32'd7, 32'hFFFF_FFFD});
    wait_idle(1'b0, cyc, errs);
    check_val("mult_start_hold", 64'(errs), 64'd0);
    check_val("mult_cycles", 64'(cyc), 64'(N + 2));
    check_val("mult_loads", 64'(m_loads - loads0), 64'd1);
    check_val("mult_ready_after", 64'(op_ready), 64'd1);
    @(posedge clock);
    #1;

    // DIV 100 / 7
    exp_q.push_back({32'd2, 32'd14});
    issue(3'(OP_DIV), 32'd100, 32'd7, mf, stalls);
    wait_idle(1'b1, cyc, errs);
    check_val("div_ready_low", 64'(errs), 64'd0);
    check_val("div_ready_after", 64'(op_ready), 64'd1);
    check_val("div_loads", 64'(d_loads), 64'd1);
    @(posedge clock);
    #1;

    // DIV by zero: flag only, no engine activity
    issue(3'(OP_DIV), 32'd5, 32'd0, mf, stalls);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (div_start || busy || !op_ready) cnt++;
    end
    check_val("dbz_quiet", 64'(cnt), 64'd0);
    check_val("dbz_flag", 64'(div_by_zero), 64'd1);
    check_val("dbz_hilo", {hi_q, lo_q}, {32'd2, 32'd14});
    check_val("dbz_loads", 64'(d_loads), 64'd1);
    @(posedge clock);
    #1;

    // MTHI / MTLO then MFHI / MFLO
    issue(3'(OP_MTHI), 32'h1234_5678, 32'd0, mf, stalls);
    issue(3'(OP_MTLO), 32'h9ABC_DEF0, 32'd0, mf, stalls);
    check_val("mt_hilo", {hi_q, lo_q}, {32'h1234_5678, 32'h9ABC_DEF0});
    issue(3'(OP_MFHI), 32'd0, 32'd0, mf, stalls);
    check_val("mfhi", 64'(mf), 64'h1234_5678);
    issue(3'(OP_MFLO), 32'd0, 32'd0, mf, stalls);
    check_val("mflo", 64'(mf), 64'h9ABC_DEF0);
    issue(3'd7, 32'hFFFF_FFFF, 32'd0, mf, stalls);
    @(negedge clock);
    check_val("undef_ignored", {hi_q, lo_q, 31'd0, busy}, {32'h1234_5678, 32'h9ABC_DEF0, 32'd0});
    @(posedge clock);
    #1;

    // MULT then MFHI presented the very next cycle: stalls until capture
    exp_q.push_back({32'd1, 32'd0});
    issue(3'(OP_MULT), 32'h0001_0000, 32'h0001_0000, mf, stalls);
    issue(3'(OP_MFHI), 32'd0, 32'd0, mf, stalls);
    check_val("mf_stall_cycles", 64'(stalls), 64'(N + 2));
    check_val("mf_after_mult", 64'(mf), 64'd1);
    issue(3'(OP_MFLO), 32'd0, 32'd0, mf, stalls);
    check_val("mflo_after_mult", 64'(mf), 64'd0);

    // Engine never acknowledges: abort after TIMEOUT cycles, HI/LO unchanged
    m_hang = 1'b1;
    loads0 = m_loads;
    exp_q.push_back({hi_q, lo_q});
    issue(3'(OP_MULT), 32'd9, 32'd9, mf, stalls);
    wait_idle(1'b0, cyc, errs);
    check_val("to_cycles", 64'(cyc), 64'(TIMEOUT));
    check_val("to_start_hold", 64'(errs), 64'd0);
    check_val("to_flag", 64'(timeout_err), 64'd1);
    check_val("to_start_low", 64'(mult_start), 64'd0);
    check_val("to_loads", 64'(m_loads - loads0), 64'd0);
    m_hang = 1'b0;
    @(posedge clock);
    #1;

    // Async reset in the middle of M_DONE
    issue(3'(OP_MULT), 32'd3, 32'd4, mf, stalls);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (!mult_fim) cnt++;
      if (cnt == 5) break;
    end
    check_val("mid_done_reached", 64'(cnt), 64'd5);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_start", {mult_start, div_start, busy}, 3'b0);
    check_val("arst_hilo", {hi_q, lo_q}, 64'd0);
    check_val("arst_sticky", {div_by_zero, timeout_err}, 2'b0);
    check_val("arst_ops", {mult_op1, mult_op2}, 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_val("arst_ready", 64'(op_ready), 64'd1);
    repeat (3) @(negedge clock);
    check_val("arst_stay_idle", {busy, mult_start}, 2'b0);
    check_val("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
Multiply/divide control stage that sits directly downstream of the CPU decode stage and upstream of the sequential multiplier and divider engines. It accepts MULT/DIV/MTHI/MTLO/MFHI/MFLO requests, registers operands and sequences the engine start/fim handshake. It captures engine hi/lo results into the architectural HI/LO registers and stalls the pipeline while an engine is busy.

Parameters:
WIDTH, 32, operand/result width
TIMEOUT, 40, max cycles in any wait state before abort

Ports:
clock  in  1  system clock
reset  in  1  async active-high reset
op_valid  in  1  request present this cycle
op_code  in  3  request opcode (package enum)
rs_val  in  WIDTH  operand 1 / MTHI/MTLO source
rt_val  in  WIDTH  operand 2
op_ready  out  1  request accepted this cycle
stall  out  1  pipeline stall
mf_data  out  WIDTH  MFHI/MFLO result
mult_start  out  1  multiplier start (level, held)
mult_op1, mult_op2  out  WIDTH  registered operands
mult_hi, mult_lo  in  WIDTH  multiplier result
mult_fim  in  1  multiplier idle/done (high when idle)
div_start  out  1  divider start (level, held)
div_op1, div_op2  out  WIDTH  registered operands
div_hi, div_lo  in  WIDTH  remainder / quotient
div_fim  in  1  divider idle/done
hi_q, lo_q  out  WIDTH  architectural HI/LO
busy  out  1  engine operation in flight
div_by_zero  out  1  sticky, set by DIV with rt_val==0
timeout_err  out  1  sticky, set on handshake timeout

Behaviour:
- Interface: one clock `clock`; reset `reset` is asynchronous and active-high.
- Reset, async at any time including mid-operation: state IDLE; hi_q, lo_q, engine operand regs = 0; mult_start, div_start, busy, div_by_zero, timeout_err, stall = 0.
- FSM states:
  - IDLE
  - M_ACK: start held, waiting for mult_fim=0
  - M_DONE: waiting for mult_fim=1
  - D_ACK
  - D_DONE
- op_ready = (state==IDLE). Accept = op_valid && op_ready.
- busy = state != IDLE.
- stall = op_valid && !op_ready, combinational.
- Accept actions, next edge:
  - MULT: latch rs/rt into mult_op1/op2; go to M_ACK.
  - DIV with rt_val!=0: latch into div_op1/op2; go to D_ACK.
  - DIV with rt_val==0: no engine start; HI/LO unchanged; div_by_zero<=1; stay IDLE.
  - MTHI: hi_q<=rs_val. MTLO: lo_q<=rs_val.
  - MFHI/MFLO: mf_data = hi_q / lo_q combinationally in the accept cycle; no state change.
  - NOP or undefined code: ignored.
- Engine start is combinational and registered-state based:
  - mult_start = (M_ACK) || (M_DONE && !mult_fim).
  - Start drops in the same cycle fim is seen high, so the engine never sees start with fim=1 after completion and cannot restart.
  - div_start is symmetric.
- Transitions:
  - M_ACK -> M_DONE when mult_fim==0.
  - M_DONE -> IDLE when mult_fim==1; same edge hi_q<=mult_hi, lo_q<=mult_lo.
  - Divider path is identical (D_ACK/D_DONE, div_hi/div_lo).
- Operand regs are held stable from accept until return to IDLE.
- Timeout counter:
  - Cleared on entry to each wait state; increments each cycle in a wait state.
  - At TIMEOUT: timeout_err<=1, state IDLE, start low, HI/LO unchanged.
- Only one engine is active at a time; no request is accepted while busy.
- MF/MT requests issued while busy stall until the result is captured; the captured value is visible the cycle after capture.
- Sticky flags clear only on reset.

Decomposition:
- Package hilo_pkg holds:
  - op_code enum: NOP=0, MULT=1, DIV=2, MTHI=3, MTLO=4, MFHI=5, MFLO=6.
  - State enum.
  - WIDTH default.
- One natural sub-module: eng_handshake, instantiated twice (mult, div). It contains the ACK/DONE sub-FSM, combinational start, timeout counter and a done/timeout pulse.
- The top level keeps the HI/LO registers and the opcode decode.

Test Plan:
- Bench uses behavioural engine models with fim high when idle and programmable latency N (default 33).
- MULT rs=7, rt=0xFFFFFFFD -> mult_start held until fim returns high; hi_q=0xFFFFFFFF, lo_q=0xFFFFFFEB at that edge; mult_start low in that cycle; engine load count = 1.
- DIV rs=100, rt=7 -> lo_q=14, hi_q=2; op_ready low throughout, high the cycle after capture.
- DIV rs=5, rt=0 -> div_by_zero=1, div_start never high, HI/LO unchanged, op_ready stays high.
- MULT, then MFHI presented next cycle -> stall=1 until capture; MFHI then returns the new hi_q.
- Engine model never drops fim -> timeout_err=1 after TIMEOUT cycles, state IDLE, start low.
- Reset asserted mid-M_DONE -> same-cycle async: mult_start=0, hi_q=lo_q=0, op_ready=1 after release.
